// File: rtl/frame_memory_arbiter_if.sv
// Read-port, write-port and memory-pin bundle for the frame memory arbiter.
// slave = arbiter side, master = controllers plus memory side.
interface frame_memory_arbiter_if #(
    parameter int DATA_WIDTH  = 96,
    parameter int ADDR_WIDTH  = 16,
    parameter int WFIFO_DEPTH = 8
);
    localparam int LEVEL_WIDTH = $clog2(WFIFO_DEPTH) + 1;

    logic                   i_rd_req;
    logic [ADDR_WIDTH-1:0]  i_rd_addr;
    logic                   o_rd_gnt;
    logic                   o_rd_rvalid;
    logic [DATA_WIDTH-1:0]  o_rd_rdata;

    logic                   i_wr_valid;
    logic [ADDR_WIDTH-1:0]  i_wr_addr;
    logic [DATA_WIDTH-1:0]  i_wr_data;
    logic                   o_wr_ready;
    logic [LEVEL_WIDTH-1:0] o_wfifo_level;

    logic                   o_mem_csn;
    logic                   o_mem_wen;
    logic [ADDR_WIDTH-1:0]  o_mem_addr;
    logic [DATA_WIDTH-1:0]  o_mem_din;
    logic [DATA_WIDTH-1:0]  i_mem_dout;

    modport slave (
        input  i_rd_req,
        input  i_rd_addr,
        output o_rd_gnt,
        output o_rd_rvalid,
        output o_rd_rdata,
        input  i_wr_valid,
        input  i_wr_addr,
        input  i_wr_data,
        output o_wr_ready,
        output o_wfifo_level,
        output o_mem_csn,
        output o_mem_wen,
        output o_mem_addr,
        output o_mem_din,
        input  i_mem_dout
    );

    modport master (
        output i_rd_req,
        output i_rd_addr,
        input  o_rd_gnt,
        input  o_rd_rvalid,
        input  o_rd_rdata,
        output i_wr_valid,
        output i_wr_addr,
        output i_wr_data,
        input  o_wr_ready,
        input  o_wfifo_level,
        input  o_mem_csn,
        input  o_mem_wen,
        input  o_mem_addr,
        input  o_mem_din,
        output i_mem_dout
    );
endinterface

// File: rtl/frame_memory_arbiter.sv
// Single-port frame memory arbiter: reads first, writes queued in a FIFO,
// with a starvation counter that forces a write slot after MAX_WAIT lost rounds.
module frame_memory_arbiter #(
    parameter int DATA_WIDTH  = 96,
    parameter int ADDR_DEPTH  = 65536,
    parameter int ADDR_WIDTH  = $clog2(ADDR_DEPTH),
    parameter int WFIFO_DEPTH = 8,
    parameter int MAX_WAIT    = 4
) (
    input  logic                  i_clk,
    input  logic                  rst_n,
    frame_memory_arbiter_if.slave bus
);
    localparam int PTR_W  = $clog2(WFIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(WFIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wentry_t;

    typedef enum logic [1:0] {
        ISSUE_IDLE,
        ISSUE_RD,
        ISSUE_WR
    } issue_e;

    wentry_t             fifo_q [WFIFO_DEPTH];
    wentry_t             head;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [1:0]          rv_sr;

    logic                mem_csn;
    logic                mem_wen;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;

    logic   empty;
    logic   full;
    logic   push;
    logic   pop;
    logic   force_write;
    logic   rd_gnt;
    issue_e issue;

    assign empty       = (level == '0);
    assign full        = (level == FULL_LVL);
    assign push        = bus.i_wr_valid && !full;
    assign force_write = (wait_cnt >= WAIT_MAX) && !empty;
    assign rd_gnt      = bus.i_rd_req && !force_write;
    assign pop         = !rd_gnt && !empty;
    assign head        = fifo_q[rd_ptr];

    always_comb begin
        issue = ISSUE_IDLE;
        unique case (1'b1)
            rd_gnt:  issue = ISSUE_RD;
            pop:     issue = ISSUE_WR;
            default: issue = ISSUE_IDLE;
        endcase
    end

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{addr: bus.i_wr_addr, data: bus.i_wr_data};
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Counts rounds a queued write has lost to a read.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (empty || pop) begin
            wait_cnt <= '0;
        end else if (rd_gnt && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_csn  <= 1'b1;
            mem_wen  <= 1'b1;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            unique case (issue)
                ISSUE_RD: begin
                    mem_csn  <= 1'b0;
                    mem_wen  <= 1'b1;
                    mem_addr <= bus.i_rd_addr;
                end
                ISSUE_WR: begin
                    mem_csn  <= 1'b0;
                    mem_wen  <= 1'b0;
                    mem_addr <= head.addr;
                    mem_din  <= head.data;
                end
                default: begin
                    mem_csn <= 1'b1;
                    mem_wen <= 1'b1;
                end
            endcase
        end
    end

    // Pin register stage plus one cycle of memory latency.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_sr <= '0;
        end else begin
            rv_sr <= {rv_sr[0], rd_gnt};
        end
    end

    assign bus.o_rd_gnt      = rd_gnt;
    assign bus.o_rd_rvalid   = rv_sr[1];
    assign bus.o_rd_rdata    = bus.i_mem_dout;
    assign bus.o_wr_ready    = !full;
    assign bus.o_wfifo_level = level;
    assign bus.o_mem_csn     = mem_csn;
    assign bus.o_mem_wen     = mem_wen;
    assign bus.o_mem_addr    = mem_addr;
    assign bus.o_mem_din     = mem_din;

    a_level_bound: assert property (
        @(posedge i_clk) disable iff (!rst_n) level <= FULL_LVL
    );

    a_force_blocks_read: assert property (
        @(posedge i_clk) disable iff (!rst_n) force_write |-> !rd_gnt
    );
endmodule

// File: tb/tb_frame_memory_arbiter.sv
// Directed bench for frame_memory_arbiter: vector table for the fill and
// starvation pattern, hand sequences for single read, push/pop and reset.
module tb_frame_memory_arbiter;
    localparam int DW = 96;
    localparam int AW = 16;

    typedef struct {
        logic          rd_req;
        logic          wr_valid;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          gnt;
        logic          rdy;
        logic          csn;
        logic          wen;
        logic [AW-1:0] addr;
        logic [3:0]    lvl;
        logic          rv;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_rec_t;

    logic i_clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    vec_t    vt [17];
    wr_rec_t wlog [$];
    logic [DW-1:0] mem_model [logic [AW-1:0]];

    frame_memory_arbiter_if #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .WFIFO_DEPTH(8)
    ) bus ();

    frame_memory_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_DEPTH (65536),
        .ADDR_WIDTH (AW),
        .WFIFO_DEPTH(8),
        .MAX_WAIT   (4)
    ) dut (
        .i_clk(i_clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (!bus.o_mem_csn) begin
            if (!bus.o_mem_wen) begin
                mem_model[bus.o_mem_addr] = bus.o_mem_din;
                wlog.push_back('{a: bus.o_mem_addr, d: bus.o_mem_din});
            end else begin
                bus.i_mem_dout <= mem_model.exists(bus.o_mem_addr) ?
                                  mem_model[bus.o_mem_addr] : '0;
            end
        end
    end

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(bit rd, bit wv, int wa, int wd,
                                 bit gnt, bit rdy, bit csn, bit wen,
                                 int addr, int lvl, bit rv);
        vec_t v;
        v.rd_req   = rd;
        v.wr_valid = wv;
        v.wr_addr  = wa[AW-1:0];
        v.wr_data  = DW'(wd);
        v.gnt      = gnt;
        v.rdy      = rdy;
        v.csn      = csn;
        v.wen      = wen;
        v.addr     = addr[AW-1:0];
        v.lvl      = lvl[3:0];
        v.rv       = rv;
        return v;
    endfunction

    task automatic drain(string tag);
        bus.i_rd_req   = 1'b0;
        bus.i_wr_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (bus.o_wfifo_level == 0 && bus.o_mem_csn) break;
        end
        chk({tag, " drained level"}, bus.o_wfifo_level, 0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_log(string tag, int n, int abase, int dbase);
        wr_rec_t r;
        chk({tag, " log size"}, wlog.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < wlog.size()) r = wlog[i];
            else r = '{a: '1, d: '1};
            chk($sformatf("%s w%0d addr", tag, i), r.a, abase + i);
            chk($sformatf("%s w%0d data", tag, i), r.d, dbase + i);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        //       rd wv wa      wd       gnt rdy csn wen addr    lvl rv
        vt[0]  = mkv(1, 1, 'h100, 'hD000, 1, 1, 1, 1, 'h0000, 0, 0);
        vt[1]  = mkv(1, 1, 'h101, 'hD001, 1, 1, 0, 1, 'h0040, 1, 0);
        vt[2]  = mkv(1, 1, 'h102, 'hD002, 1, 1, 0, 1, 'h0040, 2, 1);
        vt[3]  = mkv(1, 1, 'h103, 'hD003, 1, 1, 0, 1, 'h0040, 3, 1);
        vt[4]  = mkv(1, 1, 'h104, 'hD004, 1, 1, 0, 1, 'h0040, 4, 1);
        vt[5]  = mkv(1, 1, 'h105, 'hD005, 0, 1, 0, 1, 'h0040, 5, 1);
        vt[6]  = mkv(1, 1, 'h106, 'hD006, 1, 1, 0, 0, 'h0100, 5, 1);
        vt[7]  = mkv(1, 1, 'h107, 'hD007, 1, 1, 0, 1, 'h0040, 6, 0);
        vt[8]  = mkv(1, 1, 'h108, 'hD008, 1, 1, 0, 1, 'h0040, 7, 1);
        vt[9]  = mkv(1, 1, 'h1FF, 'hDEAD, 1, 0, 0, 1, 'h0040, 8, 1);
        vt[10] = mkv(1, 0, 0,     0,      0, 0, 0, 1, 'h0040, 8, 1);
        vt[11] = mkv(1, 0, 0,     0,      1, 1, 0, 0, 'h0101, 7, 1);
        vt[12] = mkv(1, 0, 0,     0,      1, 1, 0, 1, 'h0040, 7, 0);
        vt[13] = mkv(1, 0, 0,     0,      1, 1, 0, 1, 'h0040, 7, 1);
        vt[14] = mkv(1, 0, 0,     0,      1, 1, 0, 1, 'h0040, 7, 1);
        vt[15] = mkv(1, 0, 0,     0,      0, 1, 0, 1, 'h0040, 7, 1);
        vt[16] = mkv(1, 0, 0,     0,      1, 1, 0, 0, 'h0102, 6, 1);

        rst_n          = 1'b0;
        bus.i_rd_req   = 1'b0;
        bus.i_rd_addr  = '0;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_addr  = '0;
        bus.i_wr_data  = '0;
        repeat (3) @(negedge i_clk);
        rst_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            chk($sformatf("idle%0d csn", c), bus.o_mem_csn, 1);
            chk($sformatf("idle%0d wen", c), bus.o_mem_wen, 1);
            chk($sformatf("idle%0d rvalid", c), bus.o_rd_rvalid, 0);
            chk($sformatf("idle%0d ready", c), bus.o_wr_ready, 1);
            chk($sformatf("idle%0d level", c), bus.o_wfifo_level, 0);
        end
        @(posedge i_clk);
        #1;

        wlog.delete();
        bus.i_rd_addr = 16'h0040;
        for (int i = 0; i < 17; i++) begin
            bus.i_rd_req   = vt[i].rd_req;
            bus.i_wr_valid = vt[i].wr_valid;
            bus.i_wr_addr  = vt[i].wr_addr;
            bus.i_wr_data  = vt[i].wr_data;
            @(negedge i_clk);
            chk($sformatf("vec%0d gnt", i), bus.o_rd_gnt, vt[i].gnt);
            chk($sformatf("vec%0d ready", i), bus.o_wr_ready, vt[i].rdy);
            chk($sformatf("vec%0d csn", i), bus.o_mem_csn, vt[i].csn);
            chk($sformatf("vec%0d wen", i), bus.o_mem_wen, vt[i].wen);
            chk($sformatf("vec%0d addr", i), bus.o_mem_addr, vt[i].addr);
            chk($sformatf("vec%0d level", i), bus.o_wfifo_level, vt[i].lvl);
            chk($sformatf("vec%0d rvalid", i), bus.o_rd_rvalid, vt[i].rv);
            @(posedge i_clk);
            #1;
        end
        drain("fill");
        check_log("fill", 9, 'h100, 'hD000);

        mem_model[16'h0012] = 96'hABC;
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 16'h0012;
        @(negedge i_clk);
        chk("single gnt", bus.o_rd_gnt, 1);
        @(posedge i_clk);
        #1;
        bus.i_rd_req = 1'b0;
        @(negedge i_clk);
        chk("single csn", bus.o_mem_csn, 0);
        chk("single wen", bus.o_mem_wen, 1);
        chk("single addr", bus.o_mem_addr, 16'h0012);
        chk("single early rvalid", bus.o_rd_rvalid, 0);
        @(negedge i_clk);
        chk("single rvalid", bus.o_rd_rvalid, 1);
        chk("single rdata", bus.o_rd_rdata, 96'hABC);
        @(negedge i_clk);
        chk("single rvalid drop", bus.o_rd_rvalid, 0);
        chk("single csn idle", bus.o_mem_csn, 1);
        @(posedge i_clk);
        #1;

        wlog.delete();
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            bus.i_wr_valid = 1'b1;
            bus.i_wr_addr  = AW'(16'h200 + i);
            bus.i_wr_data  = DW'(32'hE000 + i);
            @(posedge i_clk);
            #1;
        end
        bus.i_rd_req  = 1'b0;
        bus.i_wr_addr = 16'h0203;
        bus.i_wr_data = DW'(32'hE003);
        @(negedge i_clk);
        chk("pp level before", bus.o_wfifo_level, 3);
        chk("pp ready", bus.o_wr_ready, 1);
        @(posedge i_clk);
        #1;
        bus.i_wr_valid = 1'b0;
        @(negedge i_clk);
        chk("pp level after", bus.o_wfifo_level, 3);
        chk("pp first write addr", bus.o_mem_addr, 16'h0200);
        @(posedge i_clk);
        #1;
        drain("pp");
        check_log("pp", 4, 'h200, 'hE000);

        wlog.delete();
        bus.i_rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.i_wr_valid = 1'b1;
            bus.i_wr_addr  = AW'(16'h300 + i);
            bus.i_wr_data  = DW'(32'hF000 + i);
            @(posedge i_clk);
            #1;
        end
        bus.i_rd_req   = 1'b0;
        bus.i_wr_valid = 1'b0;
        chk("rst pre level", bus.o_wfifo_level, 5);
        chk("rst pre rvalid", bus.o_rd_rvalid, 1);
        chk("rst pre csn", bus.o_mem_csn, 0);
        rst_n = 1'b0;
        #1;
        chk("rst csn", bus.o_mem_csn, 1);
        chk("rst wen", bus.o_mem_wen, 1);
        chk("rst level", bus.o_wfifo_level, 0);
        chk("rst rvalid", bus.o_rd_rvalid, 0);
        chk("rst ready", bus.o_wr_ready, 1);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            chk($sformatf("post rst%0d rvalid", c), bus.o_rd_rvalid, 0);
            chk($sformatf("post rst%0d csn", c), bus.o_mem_csn, 1);
        end
        chk("post rst no stale write", wlog.size(), 0);
        chk("post rst level", bus.o_wfifo_level, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
